// File: rtl/fir_mac_sequencer.sv
// Time-multiplexed FIR controller: one signed 16x16 MAC is stepped over NTAPS taps per sample.
// Optional build macro FIR_SAT_EN saturates the output word instead of truncating it.
module fir_mac_sequencer #(
    parameter int NTAPS     = 19,
    parameter int ACC_W     = 40,
    parameter int OUT_SHIFT = 15
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic        s_axis_data_tvalid,
    output logic        s_axis_data_tready,
    input  logic [15:0] s_axis_data_tdata,
    output logic        m_axis_data_tvalid,
    input  logic        m_axis_data_tready,
    output logic [15:0] m_axis_data_tdata,
    input  logic        cfg_coef_we,
    input  logic [4:0]  cfg_coef_addr,
    input  logic [15:0] cfg_coef_data,
    output logic        cfg_coef_err,
    output logic        busy
);

    localparam int TAP_W = $clog2(NTAPS);

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

    state_t                   state, state_next;
    logic [TAP_W-1:0]         tap;
    logic signed [15:0]       x    [NTAPS];
    logic signed [15:0]       coef [NTAPS];
    logic signed [ACC_W-1:0]  acc, acc_next;
    logic signed [31:0]       x_ext, c_ext, prod;
    logic [15:0]              out_word;
    logic                     accept, last_tap, coef_ok;

    function automatic logic signed [15:0] default_coef(input int i);
        case (i)
            0, 18:   default_coef = 16'sd26;
            1, 17:   default_coef = 16'sd270;
            2, 16:   default_coef = 16'sd963;
            3, 15:   default_coef = 16'sd2424;
            4, 14:   default_coef = 16'sd4869;
            5, 13:   default_coef = 16'sd8259;
            6, 12:   default_coef = 16'sd12194;
            7, 11:   default_coef = 16'sd15948;
            8, 10:   default_coef = 16'sd18666;
            9:       default_coef = 16'sd19660;
            default: default_coef = 16'sd0;
        endcase
    endfunction

    // Both AXI-Stream ports: a beat transfers on the rising edge where tvalid && tready;
    // tvalid never waits on tready, and ready/valid are decoded from the state register only.
    assign s_axis_data_tready = (state == IDLE);
    assign m_axis_data_tvalid = (state == OUT);
    assign busy               = (state != IDLE);

    assign accept   = s_axis_data_tvalid && (state == IDLE);
    assign last_tap = (tap == TAP_W'(NTAPS - 1));
    assign coef_ok  = (state == IDLE) && ({1'b0, cfg_coef_addr} < 6'(NTAPS));

    assign x_ext    = {{16{x[tap][15]}}, x[tap]};
    assign c_ext    = {{16{coef[tap][15]}}, coef[tap]};
    assign prod     = x_ext * c_ext;
    assign acc_next = acc + {{(ACC_W-32){prod[31]}}, prod};

`ifdef FIR_SAT_EN
    logic signed [ACC_W-1:0] shifted;
    assign shifted = acc_next >>> OUT_SHIFT;
    always_comb begin
        out_word = shifted[15:0];
        // Bits above the 16-bit window must all match the sign, otherwise clamp.
        if (!(&shifted[ACC_W-1:15]) && (|shifted[ACC_W-1:15]))
            out_word = shifted[ACC_W-1] ? 16'h8000 : 16'h7fff;
    end
`else
    assign out_word = acc_next[OUT_SHIFT+15:OUT_SHIFT];
`endif

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (s_axis_data_tvalid) state_next = MAC;
            MAC:     if (last_tap)           state_next = OUT;
            OUT:     if (m_axis_data_tready) state_next = IDLE;
            default:                         state_next = IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            for (int i = 0; i < NTAPS; i++) begin
                x[i]    <= '0;
                coef[i] <= default_coef(i);
            end
            acc               <= '0;
            tap               <= '0;
            m_axis_data_tdata <= '0;
            cfg_coef_err      <= 1'b0;
        end else begin
            cfg_coef_err <= cfg_coef_we && !coef_ok;
            // Lands on the same edge as an accept, so the first MAC cycle already sees it.
            if (cfg_coef_we && coef_ok)
                coef[cfg_coef_addr[TAP_W-1:0]] <= cfg_coef_data;
            case (state)
                IDLE: begin
                    if (accept) begin
                        for (int k = NTAPS - 1; k > 0; k--) x[k] <= x[k-1];
                        x[0] <= s_axis_data_tdata;
                        acc  <= '0;
                        tap  <= '0;
                    end
                end
                MAC: begin
                    acc <= acc_next;
                    tap <= tap + 1'b1;
                    if (last_tap) m_axis_data_tdata <= out_word;
                end
                default: ;
            endcase
        end
    end

endmodule
